// File: rtl/sspis_pkg.sv
// Shared types and constants for the SPI-slave to register-bus bridge.
package sspis_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_WDATA  = 3'd3,
        ST_WR_BUS = 3'd4,
        ST_RD_BUS = 3'd5,
        ST_RDATA  = 3'd6,
        ST_IGNORE = 3'd7
    } state_e;

    localparam logic [7:0]  CMD_WRITE       = 8'h00;
    localparam logic [7:0]  CMD_READ        = 8'h01;
    localparam logic [31:0] RD_TIMEOUT_DATA = 32'hFFFF_FFFF;

    function automatic logic [2:0] sat_inc3(input logic [2:0] v);
        return (v == 3'd7) ? v : v + 3'd1;
    endfunction

endpackage

// File: rtl/sspis_reg_bridge_if.sv
// Register-bus handshake between the SPI bridge (master) and a target (slave).
interface sspis_reg_bridge_if;
    logic        reg_cs;
    logic        reg_wr;
    logic [7:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [3:0]  reg_be;
    logic [31:0] reg_rdata;
    logic        reg_ack;

    modport master (output reg_cs, reg_wr, reg_addr, reg_wdata, reg_be,
                    input  reg_rdata, reg_ack);
    modport slave  (input  reg_cs, reg_wr, reg_addr, reg_wdata, reg_be,
                    output reg_rdata, reg_ack);
endinterface

// File: rtl/sspis_sync.sv
// Two-flop synchronizers for the SPI pins plus edge detection on sck and ssn.
module sspis_sync (
    input  logic clk,
    input  logic reset,
    input  logic sck,
    input  logic ssn,
    input  logic si,
    output logic sck_rise,
    output logic sck_fall,
    output logic ssn_rise,
    output logic ssn_fall,
    output logic si_s
);
    // Channel 0 is sck (idles low), channel 1 is ssn (idles high).
    localparam logic [1:0] RST_VAL = 2'b10;

    logic [1:0] pin;
    logic [1:0] rise;
    logic [1:0] fall;
    logic [1:0] si_q;

    assign pin = {ssn, sck};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_edge
            logic [2:0] sh_q;
            always_ff @(posedge clk) begin
                if (reset) sh_q <= {3{RST_VAL[gi]}};
                else       sh_q <= {sh_q[1:0], pin[gi]};
            end
            assign rise[gi] =  sh_q[1] & ~sh_q[2];
            assign fall[gi] = ~sh_q[1] &  sh_q[2];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) si_q <= 2'b00;
        else       si_q <= {si_q[0], si};
    end

    assign sck_rise = rise[0];
    assign sck_fall = fall[0];
    assign ssn_rise = rise[1];
    assign ssn_fall = fall[1];
    assign si_s     = si_q[1];
endmodule

// File: rtl/sspis_reg_bridge.sv
// SPI mode-0 slave that turns each framed command into one 32-bit reg-bus access.
module sspis_reg_bridge
    import sspis_pkg::*;
#(
    parameter int DUMMY_BYTES = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sck,
    input  logic                ssn,
    input  logic                si,
    output logic                so,
    output logic                so_en,
    sspis_reg_bridge_if.master  bus
);
    localparam logic [2:0] FIRST_DATA = 3'(2 + DUMMY_BYTES);

    logic sck_rise, sck_fall, ssn_rise, ssn_fall, si_s;

    sspis_sync u_sync (
        .clk      (clk),
        .reset    (reset),
        .sck      (sck),
        .ssn      (ssn),
        .si       (si),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .ssn_rise (ssn_rise),
        .ssn_fall (ssn_fall),
        .si_s     (si_s)
    );

    state_e      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [2:0]  byte_cnt_q, byte_cnt_d;
    logic [6:0]  rx_sh_q, rx_sh_d;
    logic [7:0]  tx_sh_q, tx_sh_d;
    logic        is_rd_q, is_rd_d;
    logic        ended_q, ended_d;
    logic [7:0]  addr_sh_q, addr_sh_d;
    logic [23:0] wr_sh_q, wr_sh_d;
    logic [31:0] rd_word_q, rd_word_d;
    logic [31:0] rd_sh_q, rd_sh_d;
    logic        rd_valid_q, rd_valid_d;
    logic        cs_q, cs_d;
    logic        wr_q, wr_d;
    logic [7:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [7:0]  rx_byte;
    logic [31:0] data_word;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            rx_sh_q    <= '0;
            tx_sh_q    <= '0;
            is_rd_q    <= 1'b0;
            ended_q    <= 1'b0;
            addr_sh_q  <= '0;
            wr_sh_q    <= '0;
            rd_word_q  <= '0;
            rd_sh_q    <= '0;
            rd_valid_q <= 1'b0;
            cs_q       <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            rx_sh_q    <= rx_sh_d;
            tx_sh_q    <= tx_sh_d;
            is_rd_q    <= is_rd_d;
            ended_q    <= ended_d;
            addr_sh_q  <= addr_sh_d;
            wr_sh_q    <= wr_sh_d;
            rd_word_q  <= rd_word_d;
            rd_sh_q    <= rd_sh_d;
            rd_valid_q <= rd_valid_d;
            cs_q       <= cs_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        rx_sh_d    = rx_sh_q;
        tx_sh_d    = tx_sh_q;
        is_rd_d    = is_rd_q;
        ended_d    = ended_q;
        addr_sh_d  = addr_sh_q;
        wr_sh_d    = wr_sh_q;
        rd_word_d  = rd_word_q;
        rd_sh_d    = rd_sh_q;
        rd_valid_d = rd_valid_q;
        cs_d       = cs_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rx_byte    = {rx_sh_q, si_s};
        data_word  = rd_valid_q ? rd_word_q : RD_TIMEOUT_DATA;

        // An ack always closes the bus cycle; a late read ack is simply discarded.
        if (cs_q && bus.reg_ack) begin
            cs_d = 1'b0;
            if (state_q == ST_RD_BUS) begin
                rd_word_d  = bus.reg_rdata;
                rd_valid_d = 1'b1;
                state_d    = ST_RDATA;
            end else if (state_q == ST_WR_BUS) begin
                state_d = ST_IGNORE;
            end
        end

        if (state_q == ST_IDLE) begin
            if (ssn_fall) begin
                state_d    = ST_CMD;
                bit_cnt_d  = '0;
                byte_cnt_d = '0;
                tx_sh_d    = '0;
                ended_d    = 1'b0;
                is_rd_d    = 1'b0;
                rd_valid_d = 1'b0;
            end
        end else if (ended_q || ssn_rise) begin
            // Frame over: leave only once no bus cycle is outstanding.
            ended_d = 1'b1;
            if (!cs_q) state_d = ST_IDLE;
        end else begin
            if (sck_rise) begin
                rx_sh_d   = rx_byte[6:0];
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    byte_cnt_d = sat_inc3(byte_cnt_q);
                    case (state_q)
                        ST_CMD: begin
                            if (rx_byte == CMD_WRITE) begin
                                state_d = ST_ADDR;
                            end else if (rx_byte == CMD_READ) begin
                                state_d = ST_ADDR;
                                is_rd_d = 1'b1;
                            end else begin
                                state_d = ST_IGNORE;
                            end
                        end
                        ST_ADDR: begin
                            addr_sh_d = rx_byte;
                            if (is_rd_q) begin
                                cs_d    = 1'b1;
                                wr_d    = 1'b0;
                                addr_d  = rx_byte;
                                state_d = ST_RD_BUS;
                            end else begin
                                state_d = ST_WDATA;
                            end
                        end
                        ST_WDATA: begin
                            wr_sh_d = {wr_sh_q[15:0], rx_byte};
                            if (byte_cnt_q == 3'd5) begin
                                cs_d    = 1'b1;
                                wr_d    = 1'b1;
                                addr_d  = addr_sh_q;
                                wdata_d = {wr_sh_q, rx_byte};
                                state_d = ST_WR_BUS;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            if (sck_fall) begin
                if (bit_cnt_q == 3'd0) begin
                    // Byte boundary: present the MSB of the next outgoing byte.
                    tx_sh_d = 8'h00;
                    if (state_q == ST_RD_BUS || state_q == ST_RDATA) begin
                        if (byte_cnt_q == FIRST_DATA) begin
                            tx_sh_d = data_word[31:24];
                            rd_sh_d = {data_word[23:0], 8'h00};
                            state_d = ST_RDATA;
                        end else if (byte_cnt_q > FIRST_DATA) begin
                            tx_sh_d = rd_sh_q[31:24];
                            rd_sh_d = {rd_sh_q[23:0], 8'h00};
                        end
                    end
                end else begin
                    tx_sh_d = {tx_sh_q[6:0], 1'b0};
                end
            end
        end
    end

    assign so_en         = (state_q != ST_IDLE) && !ended_q;
    assign so            = so_en && tx_sh_q[7];
    assign bus.reg_cs    = cs_q;
    assign bus.reg_wr    = wr_q;
    assign bus.reg_addr  = addr_q;
    assign bus.reg_wdata = wdata_q;
    assign bus.reg_be    = {4{cs_q}};
endmodule

// File: doc/sspis_reg_bridge.md
# sspis_reg_bridge

SPI slave (responder) that terminates an external SPI mode-0 master and converts each framed command into a single 32-bit register-bus transaction. It sits between the chip's SPI pads and a reg-bus target (the same reg_cs/reg_wr/reg_addr/reg_wdata/reg_be/reg_rdata/reg_ack handshake used by the on-chip peripherals). It lets an off-chip host read and write internal registers. All SPI inputs are oversampled in the system clock domain; no sck-clocked logic.

## Interface
- DUMMY_BYTES, 1: turnaround bytes between address and read data (≥1)
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- sck  in  1  SPI clock from host, asynchronous
- ssn  in  1  SPI chip select, active-low, asynchronous
- si  in  1  serial data from host (MOSI)
- so  out  1  serial data to host (MISO)
- so_en  out  1  pad output enable for so; high while selected
- reg_cs  out  1  bus request; held until reg_ack
- reg_wr  out  1  1 = write, 0 = read; stable while reg_cs
- reg_addr  out  8  byte address from frame
- reg_wdata  out  32  write data
- reg_be  out  4  byte enables; always 4'hF when reg_cs
- reg_rdata  in  32  read data, valid with reg_ack
- reg_ack  in  1  one-cycle completion strobe

## Operation
- Frame = ssn low period; mode 0 (CPOL=0, CPHA=0), MSB first, bytes MSB first.
- Byte0 command: 8'h00 write, 8'h01 read; any other value -> IGNORE for rest of frame, no bus access.
- Byte1: address -> reg_addr.
- Write: bytes 2..5 = wdata[31:24]..[7:0]; after bit 0 of byte 5 sampled, assert reg_cs=1, reg_wr=1. Bytes after byte 5 ignored.
- Read: after byte1 complete, assert reg_cs=1, reg_wr=0; capture reg_rdata on reg_ack. DUMMY_BYTES bytes return 8'h00; then 4 bytes return rdata[31:24]..[7:0]; further bytes return 8'h00.
- If read ack not received when first read-data byte begins, that word returns 32'hFFFF_FFFF; late ack still completes the bus cycle and is discarded.
- so returns 8'h00 during command, address and write-data bytes.
- States: IDLE, CMD, ADDR, WDATA, WR_BUS, RD_BUS, RDATA, IGNORE. IDLE->CMD on ssn fall; CMD->ADDR or IGNORE; ADDR->WDATA (write) or RD_BUS (read); WDATA->WR_BUS after 4 bytes; WR_BUS->IGNORE on ack; RD_BUS->RDATA on ack or on dummy-byte expiry; any state->IDLE on ssn rise, except bus states, which first wait for reg_ack.
- Partial frame (ssn rises before write byte 5 completes): no bus write, no side effects.
- ssn rise while reg_cs high: reg_cs held until reg_ack, then IDLE; new ssn fall during this wait is ignored until IDLE (frame lost, documented limitation).

## Timing
- sck, ssn, si pass 2-FF synchronizers; edges detected one stage later: 3 clk latency from pin to internal event.
- Requirement on host: sck high and low each ≥4 clk; ssn setup to first sck rise and hold after last sck fall ≥4 clk.
- si sampled on synchronized sck rising edge; so updated on synchronized sck falling edge; MSB of each byte presented within 3 clk of ssn fall (byte0) or the prior byte's last falling edge.
- Bit counter 3 bits, wraps 7->0 per byte; byte counter saturates at 7.
- reg_cs asserts 1 clk after the completing sample edge; deasserts the cycle after reg_ack; reg_addr/reg_wdata/reg_wr stable throughout.
- Reset values: so=0, so_en=0, reg_cs=0, reg_wr=0, reg_addr=0, reg_wdata=0, reg_be=0; state IDLE; synchronizers reset to sck=0, ssn=1, si=0.
- Reset mid-frame: all outputs to reset values immediately, including an outstanding reg_cs.

## Structure
- Package sspis_pkg: state enum, CMD_WRITE=8'h00, CMD_READ=8'h01, RD_TIMEOUT_DATA=32'hFFFF_FFFF.
- Sub-module sspis_sync: 2-FF synchronizer plus rise/fall edge detect for sck and ssn, synchronized si.

## Test plan
- Write frame 00,10,DE,AD,BE,EF at sck=clk/8 -> one reg_cs cycle, reg_wr=1, reg_addr=8'h10, reg_wdata=32'hDEADBEEF, reg_be=4'hF.
- Read frame 01,24 + 5 clocking bytes, target acks in 3 clk with 32'h12345678 -> so bytes 00,00,00,12,34,56,78.
- Read with target ack delayed past dummy byte -> so returns FF,FF,FF,FF; reg_cs drops cleanly after late ack.
- Write frame aborted after 3 data bytes by ssn rise -> no reg_cs; next full write to 8'h04 of 32'h1 completes normally.
- Command byte 8'h7F followed by 5 bytes -> reg_cs never asserts, so stays 0.
- reset asserted while reg_cs high mid-read -> next clk all outputs at reset values; subsequent read frame works.
